// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - frame readout sequencer: exposure, one-hot row walk, conversion and row handoff
module readout_sequencer #(
  parameter int ROWS          = 4,
  parameter int EXPOSE_CYCLES = 8,
  localparam int IDXW         = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            conv_done,
  input  logic            out_ready,
  output logic            busy,
  output logic            expose,
  output logic [ROWS-1:0] row_sel,
  output logic            row_sel_en,
  output logic [IDXW-1:0] row_idx,
  output logic            conv_start,
  output logic            out_valid,
  output logic            frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPOSE,
    S_CONVERT,
    S_READOUT,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      row_sel    <= ROWS'(1);
      row_idx    <= '0;
      busy       <= 1'b0;
      expose     <= 1'b0;
      row_sel_en <= 1'b0;
      conv_start <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (state != S_IDLE && abort) begin
      // abort wins over any handshake or completion in the same cycle
      state      <= S_IDLE;
      cnt        <= '0;
      row_sel    <= ROWS'(1);
      row_idx    <= '0;
      busy       <= 1'b0;
      expose     <= 1'b0;
      row_sel_en <= 1'b0;
      conv_start <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_EXPOSE;
            cnt    <= 8'(EXPOSE_CYCLES - 1);
            busy   <= 1'b1;
            expose <= 1'b1;
          end
        end
        S_EXPOSE: begin
          if (cnt == 8'd0) begin
            state      <= S_CONVERT;
            expose     <= 1'b0;
            row_sel_en <= 1'b1;
            conv_start <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_CONVERT: begin
          // conv_start marks the first cycle, where conv_done is stale
          if (conv_start) begin
            conv_start <= 1'b0;
          end else if (conv_done) begin
            state     <= S_READOUT;
            out_valid <= 1'b1;
          end
        end
        S_READOUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            row_sel   <= {row_sel[ROWS-2:0], row_sel[ROWS-1]};
            if (row_sel[ROWS-1]) begin
              state      <= S_DONE;
              row_idx    <= '0;
              row_sel_en <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              state      <= S_CONVERT;
              row_idx    <= row_idx + 1'b1;
              conv_start <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// tb/tb_readout_sequencer.sv - self-checking bench for readout_sequencer against a phase-level reference model
module tb_readout_sequencer;

  localparam int ROWS = 4;
  localparam int EXP  = 3;

  logic            clk;
  logic            reset;
  logic            start;
  logic            abort;
  logic            conv_done;
  logic            out_ready;
  logic            busy;
  logic            expose;
  logic [ROWS-1:0] row_sel;
  logic            row_sel_en;
  logic [1:0]      row_idx;
  logic            conv_start;
  logic            out_valid;
  logic            frame_done;

  readout_sequencer #(.ROWS(ROWS), .EXPOSE_CYCLES(EXP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .conv_done  (conv_done),
    .out_ready  (out_ready),
    .busy       (busy),
    .expose     (expose),
    .row_sel    (row_sel),
    .row_sel_en (row_sel_en),
    .row_idx    (row_idx),
    .conv_start (conv_start),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: frame phase, current row number, exposure cycles left, cycles spent converting
  typedef enum int {M_IDLE, M_EXP, M_CONV, M_READ, M_DONE} mph_t;
  mph_t m_ph;
  int   m_row;
  int   m_left;
  int   m_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_row = 0; m_left = 0; m_age = 0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic cd, input logic rdy);
    if (m_ph == M_IDLE) begin
      if (s) begin m_ph = M_EXP; m_left = EXP; end
    end else if (a) begin
      m_ph = M_IDLE; m_row = 0;
    end else begin
      case (m_ph)
        M_EXP: begin
          m_left--;
          if (m_left == 0) begin m_ph = M_CONV; m_age = 0; end
        end
        M_CONV: begin
          if (m_age > 0 && cd) m_ph = M_READ;
          else m_age++;
        end
        M_READ: begin
          if (rdy) begin
            if (m_row == ROWS - 1) begin m_row = 0; m_ph = M_DONE; end
            else begin m_row++; m_ph = M_CONV; m_age = 0; end
          end
        end
        default: m_ph = M_IDLE;
      endcase
    end
  endtask

  task automatic check_model();
    chk("busy", busy, m_ph != M_IDLE);
    chk("expose", expose, m_ph == M_EXP);
    chk("row_sel_en", row_sel_en, m_ph == M_CONV || m_ph == M_READ);
    chk("conv_start", conv_start, m_ph == M_CONV && m_age == 0);
    chk("out_valid", out_valid, m_ph == M_READ);
    chk("frame_done", frame_done, m_ph == M_DONE);
    chk("row_sel", row_sel, 32'd1 << m_row);
    chk("row_idx", row_idx, m_row);
    chk("onehot", $onehot(row_sel), 1);
  endtask

  task automatic step(input logic s, input logic a, input logic cd, input logic rdy);
    start = s; abort = a; conv_done = cd; out_ready = rdy;
    @(posedge clk);
    model_step(s, a, cd, rdy);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int  hold;
    bit  done_seen;
    bit  reached;
    bit  first_cs;

    start = 0; abort = 0; conv_done = 0; out_ready = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    chk("rst_row_sel", row_sel, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    step(0, 0, 0, 0);

    // zero-wait frame against absolute cycle numbers
    step(1, 0, 0, 0);
    for (int c = 1; c <= 17; c++) begin
      chk("ff_expose", expose, c <= 3);
      chk("ff_conv_start", conv_start, c == 4 || c == 7 || c == 10 || c == 13);
      if (c == 4 || c == 7 || c == 10 || c == 13) chk("ff_row_idx", row_idx, (c - 4) / 3);
      chk("ff_frame_done", frame_done, c == 16);
      chk("ff_busy", busy, c <= 16);
      step(0, 0, 1, 1);
    end

    // backpressure on row 1, stray start in CONVERT, stray conv_done throughout
    hold = 0; done_seen = 0; reached = 0;
    step(1, 0, 1, 1);
    for (int n = 0; n < 80; n++) begin
      if (m_ph == M_READ && m_row == 1 && hold < 5) begin
        chk("bp_valid", out_valid, 1);
        chk("bp_row_idx", row_idx, 1);
        chk("bp_no_conv", conv_start, 0);
        hold++;
        step(0, 0, 1, 0);
      end else begin
        if (m_ph == M_DONE) done_seen = 1;
        if (m_ph == M_IDLE && done_seen) begin reached = 1; break; end
        step(m_ph == M_CONV, 0, 1, 1);
      end
    end
    chk("bp_hold_count", hold, 5);
    chk("bp_frame_end", reached, 1);

    // back-to-back frame: start in first IDLE cycle, then abort on the row-2 handshake
    reached = 0; first_cs = 0;
    step(1, 0, 1, 1);
    for (int n = 0; n < 60; n++) begin
      if (conv_start && !first_cs) begin
        first_cs = 1;
        chk("wrap_first_row", row_sel, 4'b0001);
      end
      if (m_ph == M_READ && m_row == 2) begin
        step(0, 1, 1, 1);
        reached = 1;
        break;
      end
      step(0, 0, 1, 1);
    end
    chk("abort_reached", reached, 1);
    chk("abort_row_sel", row_sel, 4'b0001);
    chk("abort_busy", busy, 0);
    for (int n = 0; n < 4; n++) begin
      chk("abort_no_done", frame_done, 0);
      step(0, 0, 1, 1);
    end

    // asynchronous reset during READOUT on row 2
    reached = 0;
    step(1, 0, 1, 1);
    for (int n = 0; n < 60; n++) begin
      if (m_ph == M_READ && m_row == 2) begin reached = 1; break; end
      step(0, 0, 1, m_row != 2);
    end
    chk("rst_reached", reached, 1);
    reset = 1'b0;
    #1;
    chk("arst_row_sel", row_sel, 4'b0001);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_model();
    step(1, 0, 1, 1);
    for (int n = 0; n < 20; n++) step(0, 0, 1, 1);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom % 4) == 0, ($urandom % 24) == 0, $urandom % 2, $urandom % 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
